// File: rtl/mod_counter_chain.sv
// Cascaded modulo-MODULUS up/down counter with DIGITS digits, parallel load and carry/borrow chaining.
// Optional build macro COUNTER_SATURATE_EN: hold at the full-chain terminal instead of wrapping.
module mod_counter_chain #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 10,
  parameter int WIDTH   = 4
) (
  input  logic                    slowclk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] load_val,
  output logic [DIGITS*WIDTH-1:0] count_out,
  output logic                    tc_out,
  output logic                    wrap_pulse
);

  localparam logic [WIDTH-1:0] TOP_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

  if (DIGITS < 1 || MODULUS < 2 || (2 ** WIDTH) < MODULUS) begin : g_param_check
    $error("mod_counter_chain: illegal DIGITS/MODULUS/WIDTH combination");
  end

  // One modulo step of a single digit; wrap is local, the carry travels via the terminal chain.
  function automatic logic [WIDTH-1:0] step_digit(input logic [WIDTH-1:0] d,
                                                  input logic dir_up);
    logic [WIDTH-1:0] r;
    if (dir_up) begin
      if (d == TOP_VAL) r = ZERO_VAL;
      else              r = d + ONE_VAL;
    end else begin
      if (d == ZERO_VAL) r = TOP_VAL;
      else               r = d - ONE_VAL;
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] clamp_digit(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    if (d > TOP_VAL) r = TOP_VAL;
    else             r = d;
    return r;
  endfunction

  logic [DIGITS-1:0][WIDTH-1:0] digit_r;
  logic [DIGITS-1:0][WIDTH-1:0] digit_nxt_s;
  logic [DIGITS-1:0]            chain_s;
  logic                         all_term_s;
  logic                         wrap_nxt_s;
  logic                         wrap_r;

  // Terminal chain: chain_s[i] is set when every digit below i sits at its terminal value.
  always_comb begin
    logic run_s;
    run_s   = 1'b1;
    chain_s = {DIGITS{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      chain_s[i] = run_s;
      if (up) run_s = run_s & (digit_r[i] == TOP_VAL);
      else    run_s = run_s & (digit_r[i] == ZERO_VAL);
    end
    all_term_s = run_s;
  end

  assign tc_out = en & all_term_s;

  // Next-state selection: load beats count, count beats hold; reset is applied in the register.
  always_comb begin
    digit_nxt_s = digit_r;
    wrap_nxt_s  = 1'b0;
    if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_nxt_s[i] = clamp_digit(load_val[i*WIDTH +: WIDTH]);
      end
    end else if (en) begin
`ifdef COUNTER_SATURATE_EN
      if (all_term_s) begin
        digit_nxt_s = digit_r;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (chain_s[i]) digit_nxt_s[i] = step_digit(digit_r[i], up);
          else            digit_nxt_s[i] = digit_r[i];
        end
      end
      wrap_nxt_s = 1'b0;
`else
      for (int i = 0; i < DIGITS; i++) begin
        if (chain_s[i]) digit_nxt_s[i] = step_digit(digit_r[i], up);
        else            digit_nxt_s[i] = digit_r[i];
      end
      wrap_nxt_s = all_term_s;
`endif
    end else begin
      digit_nxt_s = digit_r;
      wrap_nxt_s  = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge slowclk) begin
    if (rst) begin
      digit_r <= {(DIGITS*WIDTH){1'b0}};
      wrap_r  <= 1'b0;
    end else begin
      digit_r <= digit_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  assign count_out  = digit_r;
  assign wrap_pulse = wrap_r;

endmodule

// File: tb/tb_mod_counter_chain.sv
// Directed bench for mod_counter_chain (DIGITS=2, MODULUS=10, WIDTH=4): vector table plus a
// two-instance cascade sequence.
module tb_mod_counter_chain;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       slowclk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count_out;
  logic       tc_out, wrap_pulse;

  logic       hi_rst = 1'b1, hi_load = 1'b0;
  logic [7:0] hi_load_val = 8'h00;
  logic [7:0] hi_count;
  logic       hi_tc, hi_wrap;

  always #5 slowclk = ~slowclk;

  mod_counter_chain #(.DIGITS(2), .MODULUS(10), .WIDTH(4)) u_lo (
    .slowclk(slowclk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count_out(count_out), .tc_out(tc_out), .wrap_pulse(wrap_pulse));

  mod_counter_chain #(.DIGITS(2), .MODULUS(10), .WIDTH(4)) u_hi (
    .slowclk(slowclk), .rst(hi_rst), .en(tc_out), .up(up), .load(hi_load),
    .load_val(hi_load_val), .count_out(hi_count), .tc_out(hi_tc), .wrap_pulse(hi_wrap));

  typedef struct {
    bit         rst, en, up, load;
    logic [7:0] lv;
    bit         chk_tc, exp_tc;
    logic [7:0] exp_cnt;
    bit         exp_wrap;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input bit r, e, u, l, input logic [7:0] lv, input bit ct, et,
                     input logic [7:0] ec, input bit ew);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.load = l; v.lv = lv;
    v.chk_tc = ct; v.exp_tc = et; v.exp_cnt = ec; v.exp_wrap = ew;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    // reset two cycles with en=1
    add(1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0);
    add(1, 1, 1, 0, 8'h00, 1, 0, 8'h00, 0);
    // ten up-steps from zero
    for (int k = 1; k <= 10; k++)
      add(0, 1, 1, 0, 8'h00, 1, 0, (k == 10) ? 8'h10 : 8'(k), 0);
    // full-chain wrap up
    add(0, 0, 1, 1, 8'h99, 1, 0, 8'h99, 0);
    add(0, 1, 1, 0, 8'h00, 1, 1, SAT ? 8'h99 : 8'h00, !SAT);
    add(0, 0, 1, 0, 8'h00, 1, 0, SAT ? 8'h99 : 8'h00, 0);
    // count down with borrow, then full-chain wrap down
    add(0, 0, 0, 1, 8'h10, 1, 0, 8'h10, 0);
    add(0, 1, 0, 0, 8'h00, 1, 0, 8'h09, 0);
    add(0, 1, 0, 0, 8'h00, 1, 0, 8'h08, 0);
    add(0, 0, 0, 1, 8'h00, 1, 0, 8'h00, 0);
    add(0, 1, 0, 0, 8'h00, 1, 1, SAT ? 8'h00 : 8'h99, !SAT);
    // load beats count, clamping of out-of-range digits
    add(0, 1, 1, 1, 8'hAF, 1, !SAT, 8'h99, 0);
    add(0, 0, 1, 1, 8'h5C, 1, 0, 8'h59, 0);
    // count to 45, then reset wins over load
    add(0, 0, 1, 1, 8'h43, 1, 0, 8'h43, 0);
    add(0, 1, 1, 0, 8'h00, 1, 0, 8'h44, 0);
    add(0, 1, 1, 0, 8'h00, 1, 0, 8'h45, 0);
    add(1, 1, 1, 1, 8'h77, 1, 0, 8'h00, 0);
    // hold with en=0 on a nonzero value, up toggling
    add(0, 0, 1, 1, 8'h36, 1, 0, 8'h36, 0);
    for (int k = 0; k < 5; k++)
      add(0, 0, k[0], 0, 8'h00, 1, 0, 8'h36, 0);
    // direction change: no extra step
    add(0, 0, 1, 1, 8'h09, 1, 0, 8'h09, 0);
    add(0, 1, 1, 0, 8'h00, 1, 0, 8'h10, 0);
    add(0, 1, 0, 0, 8'h00, 1, 0, 8'h09, 0);
    add(0, 1, 1, 0, 8'h00, 1, 0, 8'h10, 0);

    foreach (vq[i]) begin
      @(negedge slowclk);
      rst = vq[i].rst; en = vq[i].en; up = vq[i].up; load = vq[i].load; load_val = vq[i].lv;
      #1;
      if (vq[i].chk_tc) check("tc_out", i, 32'(tc_out), 32'(vq[i].exp_tc));
      @(posedge slowclk);
      #1;
      check("count_out", i, 32'(count_out), 32'(vq[i].exp_cnt));
      check("wrap_pulse", i, 32'(wrap_pulse), 32'(vq[i].exp_wrap));
    end

    // cascade: upper instance steps once per 100 lower steps
    @(negedge slowclk);
    rst = 1'b1; hi_rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0;
    @(negedge slowclk);
    rst = 1'b0; hi_rst = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge slowclk);
      #1;
      if (k == 99) begin
        check("chain_hi", k, 32'(hi_count), 32'h00);
        check("chain_lo", k, 32'(count_out), 32'h99);
      end
      if (k == 100) begin
        check("chain_hi", k, 32'(hi_count), 32'h01);
        check("chain_lo", k, 32'(count_out), SAT ? 32'h99 : 32'h00);
        check("chain_wrap", k, 32'(wrap_pulse), 32'(!SAT));
      end
`ifndef COUNTER_SATURATE_EN
      if (k == 199) check("chain_hi", k, 32'(hi_count), 32'h01);
      if (k == 200) check("chain_hi", k, 32'(hi_count), 32'h02);
      if (k == 300) check("chain_hi", k, 32'(hi_count), 32'h03);
`endif
    end
    @(negedge slowclk);
    en = 1'b0;
    #1;
    check("chain_tc_en0", 0, 32'(tc_out), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
